seg_mux_scheduler: RTL and testbench

//   Time-multiplexes two 4-bit hex digits onto one shared seven-segment decoder (display) and a

---
 rtl/seg_mux_scheduler.sv | 140 ++++++++++++++
 tb/tb_seg_mux_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_mux_scheduler.sv
// seg_mux_scheduler: time-multiplexes two hex nibbles onto one shared
// seven-segment decoder driving a dual common-anode display.
// Rotation is SHOW0 -> GAP0 -> SHOW1 -> GAP1 -> SHOW0. Both anodes are dark
// during the gaps so the decoder can settle on the next digit without ghosting.
// Optional build macro: SEG_MUX_LATCH_EN captures s0/s1 into shadow registers
// on every entry to SHOW0, so that a whole frame shows a coherent pair.
module seg_mux_scheduler #(
  parameter int DWELL_CYCLES = 100_000,
  parameter int BLANK_CYCLES = 4_800,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] hex_out,
  output logic [1:0] an,
  output logic       digit_sel,
  output logic       frame_tick
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHOW0 = 3'd1,
    GAP0  = 3'd2,
    SHOW1 = 3'd3,
    GAP1  = 3'd4
  } state_t;

  // Last counter value of each phase; with no gap the blank value is unused.
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
  localparam bit HAS_GAP = (BLANK_CYCLES > 0);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             dwell_done;
  logic             blank_done;
  logic [1:0]       an_next;
  logic             digit_sel_next;
  logic             tick_next;

  assign dwell_done = (cnt == DWELL_LAST);
  assign blank_done = (cnt == BLANK_LAST);

  // Next-state selection; dropping enable forces IDLE from any state.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = SHOW0;
        SHOW0:   if (dwell_done) next_state = HAS_GAP ? GAP0 : SHOW1;
        GAP0:    if (blank_done) next_state = SHOW1;
        SHOW1:   if (dwell_done) next_state = HAS_GAP ? GAP1 : SHOW0;
        GAP1:    if (blank_done) next_state = SHOW0;
        default: next_state = IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state register; gaps already point digit_sel at the next digit.
  always_comb begin
    an_next        = 2'b11;
    digit_sel_next = 1'b0;
    tick_next      = 1'b0;
    case (next_state)
      SHOW0: begin
        an_next   = 2'b10;
        tick_next = (state != SHOW0);
      end
      GAP0: begin
        digit_sel_next = 1'b1;
      end
      SHOW1: begin
        an_next        = 2'b01;
        digit_sel_next = 1'b1;
      end
      default: begin
        an_next        = 2'b11;
        digit_sel_next = 1'b0;
      end
    endcase
  end

  // State register and phase counter; the counter restarts on every state change
  // and is held at zero while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if ((next_state != state) || (state == IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Registered Moore outputs, so there is no combinational path from enable to an.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an         <= 2'b11;
      digit_sel  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      digit_sel  <= digit_sel_next;
      frame_tick <= tick_next;
    end
  end

`ifdef SEG_MUX_LATCH_EN
  logic [3:0] shadow0;
  logic [3:0] shadow1;

  // Capture the digit pair on each entry to SHOW0 so a frame never tears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow0 <= 4'h0;
      shadow1 <= 4'h0;
    end else if (tick_next) begin
      shadow0 <= s0;
      shadow1 <= s1;
    end
  end

  assign hex_out = digit_sel ? shadow1 : shadow0;
`else
  assign hex_out = digit_sel ? s1 : s0;
`endif

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// tb_seg_mux_scheduler: self-checking bench for seg_mux_scheduler.
// Instance A uses a 4-cycle dwell with 2-cycle gaps, instance B has no gaps.
module tb_seg_mux_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [3:0] s0;
  logic [3:0] s1;
  logic [3:0] hex_a, hex_b;
  logic [1:0] an_a, an_b;
  logic       dsel_a, dsel_b;
  logic       tick_a, tick_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [1:0] an_a;
    logic       dsel_a;
    logic       tick_a;
    logic [3:0] hex_a;
    logic       chk_b;
    logic [1:0] an_b;
    logic       dsel_b;
    logic       tick_b;
    logic [3:0] hex_b;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[24];

  seg_mux_scheduler #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .s0(s0), .s1(s1),
    .hex_out(hex_a), .an(an_a), .digit_sel(dsel_a), .frame_tick(tick_a)
  );

  seg_mux_scheduler #(.DWELL_CYCLES(4), .BLANK_CYCLES(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .s0(s0), .s1(s1),
    .hex_out(hex_b), .an(an_b), .digit_sel(dsel_b), .frame_tick(tick_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t makeRaw(input logic en, input logic [3:0] v0, input logic [3:0] v1,
                                   input logic [1:0] an, input logic dsel, input logic tick,
                                   input logic [3:0] hex);
    vec_t v;
    v.en = en; v.s0 = v0; v.s1 = v1;
    v.an_a = an; v.dsel_a = dsel; v.tick_a = tick; v.hex_a = hex;
    v.chk_b = 1'b0; v.an_b = 2'b11; v.dsel_b = 1'b0; v.tick_b = 1'b0; v.hex_b = 4'h0;
    return v;
  endfunction

  // Expected instance-A outputs k edges after the rotation starts (12-cycle period).
  function automatic vec_t makeVec(input int k, input logic en, input logic [3:0] v0,
                                   input logic [3:0] v1, input logic [3:0] shown0);
    int p;
    logic [1:0] an;
    logic dsel;
    p = k % 12;
    if (p < 4)       begin an = 2'b10; dsel = 1'b0; end
    else if (p < 6)  begin an = 2'b11; dsel = 1'b1; end
    else if (p < 10) begin an = 2'b01; dsel = 1'b1; end
    else             begin an = 2'b11; dsel = 1'b0; end
    return makeRaw(en, v0, v1, an, dsel, (p == 0), dsel ? v1 : shown0);
  endfunction

  task automatic applyStimulus(input vec_t v);
    enable = v.en;
    s0     = v.s0;
    s1     = v.s1;
    sb_q.push_back(v);
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " an_a"}, {6'd0, an_a}, {6'd0, e.an_a});
      chk({tag, " dsel_a"}, {7'd0, dsel_a}, {7'd0, e.dsel_a});
      chk({tag, " tick_a"}, {7'd0, tick_a}, {7'd0, e.tick_a});
      chk({tag, " hex_a"}, {4'd0, hex_a}, {4'd0, e.hex_a});
      chk({tag, " an_a_not_both_low"}, {7'd0, (an_a == 2'b00)}, 8'd0);
      if (e.chk_b) begin
        chk({tag, " an_b"}, {6'd0, an_b}, {6'd0, e.an_b});
        chk({tag, " dsel_b"}, {7'd0, dsel_b}, {7'd0, e.dsel_b});
        chk({tag, " tick_b"}, {7'd0, tick_b}, {7'd0, e.tick_b});
        chk({tag, " hex_b"}, {4'd0, hex_b}, {4'd0, e.hex_b});
        chk({tag, " an_b_not_both_low"}, {7'd0, (an_b == 2'b00)}, 8'd0);
      end
    end
  endtask

  task automatic restart(input logic [3:0] v0, input logic [3:0] v1);
    reset_n = 1'b0;
    enable  = 1'b1;
    s0      = v0;
    s1      = v1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    logic [3:0] gap1_digit0;
`ifdef SEG_MUX_LATCH_EN
    gap1_digit0 = 4'h5;
`else
    gap1_digit0 = 4'h7;
`endif

    for (int k = 0; k < 24; k++) begin
      int q;
      tbl[k] = makeVec(k, 1'b1, 4'h3, 4'hA, 4'h3);
      q = k % 8;
      tbl[k].chk_b  = 1'b1;
      tbl[k].an_b   = (q < 4) ? 2'b10 : 2'b01;
      tbl[k].dsel_b = (q >= 4);
      tbl[k].tick_b = (q == 0);
      tbl[k].hex_b  = (q >= 4) ? 4'hA : 4'h3;
    end

    // Reset held with enable high: everything dark.
    reset_n = 1'b0;
    enable  = 1'b1;
    s0      = 4'h3;
    s1      = 4'hA;
    repeat (2) @(posedge clk);
    #1;
    chk("reset an_a", {6'd0, an_a}, 8'h03);
    chk("reset tick_a", {7'd0, tick_a}, 8'h00);
    chk("reset dsel_a", {7'd0, dsel_a}, 8'h00);
    chk("reset an_b", {6'd0, an_b}, 8'h03);
`ifdef SEG_MUX_LATCH_EN
    chk("reset hex_a", {4'd0, hex_a}, 8'h00);
`else
    chk("reset hex_a", {4'd0, hex_a}, 8'h03);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // Two full periods of A, three of B.
    for (int k = 0; k < 24; k++) begin
      applyStimulus(tbl[k]);
      checkOutput($sformatf("table[%0d]", k));
    end

    // Disable during the second SHOW1 cycle, then re-enable.
    restart(4'h3, 4'hA);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(makeVec(k, 1'b1, 4'h3, 4'hA, 4'h3));
      checkOutput($sformatf("dis_run[%0d]", k));
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(makeRaw(1'b0, 4'h3, 4'hA, 2'b11, 1'b0, 1'b0, 4'h3));
      checkOutput($sformatf("disabled[%0d]", k));
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(makeVec(k, 1'b1, 4'h3, 4'hA, 4'h3));
      checkOutput($sformatf("reenable[%0d]", k));
    end

    // Asynchronous reset between edges in GAP0.
    restart(4'h3, 4'hA);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(makeVec(k, 1'b1, 4'h3, 4'hA, 4'h3));
      checkOutput($sformatf("pre_async[%0d]", k));
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset an_a", {6'd0, an_a}, 8'h03);
    chk("async_reset dsel_a", {7'd0, dsel_a}, 8'h00);
    chk("async_reset tick_a", {7'd0, tick_a}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(makeVec(k, 1'b1, 4'h3, 4'hA, 4'h3));
      checkOutput($sformatf("post_async[%0d]", k));
    end

    // s0 changes 5 -> 7 while digit 1 is lit.
    restart(4'h5, 4'h1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(makeVec(k, 1'b1, 4'h5, 4'h1, 4'h5));
      checkOutput($sformatf("latch_pre[%0d]", k));
    end
    for (int k = 6; k < 10; k++) begin
      applyStimulus(makeVec(k, 1'b1, 4'h7, 4'h1, 4'h5));
      checkOutput($sformatf("latch_show1[%0d]", k));
    end
    for (int k = 10; k < 12; k++) begin
      applyStimulus(makeVec(k, 1'b1, 4'h7, 4'h1, gap1_digit0));
      checkOutput($sformatf("latch_gap1[%0d]", k));
    end
    for (int k = 12; k < 14; k++) begin
      applyStimulus(makeVec(k, 1'b1, 4'h7, 4'h1, 4'h7));
      checkOutput($sformatf("latch_next[%0d]", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
